// File: rtl/stream_merge2_1.sv
// stream_merge2_1: pairs two valid-only 32-bit lanes through per-lane FIFOs into one 64-bit valid/ready stream
// Ports: clk, reset (sync, active-high); data_port1/valid1 = lane 1 (low half),
// data_port2/valid2 = lane 2 (high half); m_data/m_valid/m_ready/m_last = merged output;
// done, overflow, skew_err = sticky status flags.
// Optional lane strobe mismatch check enabled by defining LANE_SKEW_CHK_EN.
module stream_merge2_1 #(
  parameter int DATA_WIDTH     = 64,
  parameter int DEPTH          = 4096,
  parameter int ACTIVE_SAMPLES = 3276,
  parameter int TOTAL_SAMPLES  = 733824
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH/2-1:0] data_port1,
  input  logic                    valid1,
  input  logic [DATA_WIDTH/2-1:0] data_port2,
  input  logic                    valid2,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    done,
  output logic                    overflow,
  output logic                    skew_err
);
  localparam int LW = DATA_WIDTH / 2;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = ACTIVE_SAMPLES > 1 ? $clog2(ACTIVE_SAMPLES) : 1;
  localparam int TW = $clog2(TOTAL_SAMPLES + 1);
  localparam logic [BW-1:0] B_LAST = BW'(ACTIVE_SAMPLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TOTAL_SAMPLES - 1);
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  typedef enum logic {ST_RUN, ST_DONE} state_t;
  logic [LW-1:0] mem1 [DEPTH];
  logic [LW-1:0] mem2 [DEPTH];
  logic [AW-1:0] wptr1_q, wptr1_d, rptr1_q, rptr1_d;
  logic [AW-1:0] wptr2_q, wptr2_d, rptr2_q, rptr2_d;
  logic [CW-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [TW-1:0] total_q, total_d;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic done_q, done_d, overflow_q, overflow_d;
  logic hs, fin, load, push1, push2;
  always_comb begin
    hs         = m_valid_q && m_ready;
    // The final handshake blocks a new load so m_valid drops together with done rising
    fin        = hs && (total_q == T_LAST);
    load       = (cnt1_q != '0) && (cnt2_q != '0) && (!m_valid_q || m_ready) && (state_q == ST_RUN) && !fin;
    // A full lane still accepts a push when the pair is popped in the same cycle
    push1      = valid1 && ((cnt1_q != FULL) || load);
    push2      = valid2 && ((cnt2_q != FULL) || load);
    wptr1_d    = wptr1_q + AW'(push1);
    wptr2_d    = wptr2_q + AW'(push2);
    rptr1_d    = rptr1_q + AW'(load);
    rptr2_d    = rptr2_q + AW'(load);
    cnt1_d     = cnt1_q + CW'(push1) - CW'(load);
    cnt2_d     = cnt2_q + CW'(push2) - CW'(load);
    burst_d    = hs ? ((burst_q == B_LAST) ? '0 : burst_q + 1'b1) : burst_q;
    total_d    = total_q + TW'(hs);
    m_valid_d  = load || (m_valid_q && !hs);
    m_data_d   = load ? {mem2[rptr2_q], mem1[rptr1_q]} : m_data_q;
    // burst_d is the burst index of the word being loaded now
    m_last_d   = load ? (burst_d == B_LAST) : (m_last_q && !hs);
    state_d    = fin ? ST_DONE : state_q;
    done_d     = done_q || fin;
    overflow_d = overflow_q || (valid1 && !push1) || (valid2 && !push2);
  end
  always_ff @(posedge clk) begin
    if (push1) mem1[wptr1_q] <= data_port1;
    if (push2) mem2[wptr2_q] <= data_port2;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr1_q    <= '0;
      wptr2_q    <= '0;
      rptr1_q    <= '0;
      rptr2_q    <= '0;
      cnt1_q     <= '0;
      cnt2_q     <= '0;
      burst_q    <= '0;
      total_q    <= '0;
      state_q    <= ST_RUN;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wptr1_q    <= wptr1_d;
      wptr2_q    <= wptr2_d;
      rptr1_q    <= rptr1_d;
      rptr2_q    <= rptr2_d;
      cnt1_q     <= cnt1_d;
      cnt2_q     <= cnt2_d;
      burst_q    <= burst_d;
      total_q    <= total_d;
      state_q    <= state_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end
`ifdef LANE_SKEW_CHK_EN
  logic skew_q, skew_d;
  always_comb skew_d = skew_q || (valid1 != valid2);
  always_ff @(posedge clk) begin
    if (reset) skew_q <= 1'b0;
    else skew_q <= skew_d;
  end
  assign skew_err = skew_q;
`else
  assign skew_err = 1'b0;
`endif
  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign done     = done_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_stream_merge2_1.sv
// tb_stream_merge2_1: vector table, directed corner sequences and random traffic against a queue model
module tb_stream_merge2_1;
  localparam int DEPTH = 8;
  localparam int ACT   = 4;
  localparam int TOTAL = 12;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] data_port1 = '0, data_port2 = '0;
  logic valid1 = 1'b0, valid2 = 1'b0, m_ready = 1'b0;
  logic [63:0] m_data;
  logic m_valid, m_last, done, overflow, skew_err;
  stream_merge2_1 #(
    .DATA_WIDTH(64), .DEPTH(DEPTH), .ACTIVE_SAMPLES(ACT), .TOTAL_SAMPLES(TOTAL)
  ) dut (
    .clk(clk), .reset(reset),
    .data_port1(data_port1), .valid1(valid1),
    .data_port2(data_port2), .valid2(valid2),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .done(done), .overflow(overflow), .skew_err(skew_err)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  int nacc = 0, nlast = 0;
  logic [31:0] q1[$], q2[$];
  bit mv, ml, mdone, movf, mskew;
  logic [63:0] mdat;
  int nout, nload;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
  endtask
  task automatic model_step(input bit r, input bit v1, input logic [31:0] d1,
                            input bit v2, input logic [31:0] d2, input bit rdy);
    bit hs, ld;
    if (r) begin
      q1.delete(); q2.delete();
      mv = 0; ml = 0; mdone = 0; movf = 0; mskew = 0; mdat = '0; nout = 0; nload = 0;
      return;
    end
    hs = mv && rdy;
    if (hs) begin
      nout++;
      if (nout == TOTAL) mdone = 1;
    end
    ld = !mdone && q1.size() > 0 && q2.size() > 0 && (!mv || rdy);
    if (ld) begin
      mdat = {q2.pop_front(), q1.pop_front()};
      ml = (nload % ACT) == ACT - 1;
      nload++;
      mv = 1;
    end else if (hs) begin
      mv = 0; ml = 0;
    end
    if (mdone) mv = 0;
    if (v1) begin
      if (q1.size() < DEPTH) q1.push_back(d1); else movf = 1;
    end
    if (v2) begin
      if (q2.size() < DEPTH) q2.push_back(d2); else movf = 1;
    end
`ifdef LANE_SKEW_CHK_EN
    if (v1 != v2) mskew = 1;
`endif
  endtask
  task automatic cyc(input bit r, input bit v1, input logic [31:0] d1,
                     input bit v2, input logic [31:0] d2, input bit rdy);
    reset = r; valid1 = v1; data_port1 = d1; valid2 = v2; data_port2 = d2; m_ready = rdy;
    if (!r && m_valid && rdy) begin
      nacc++;
      if (m_last) nlast++;
    end
    @(posedge clk);
    #1;
    model_step(r, v1, d1, v2, d2, rdy);
    chk("m_valid", {63'd0, m_valid}, {63'd0, mv});
    chk("done", {63'd0, done}, {63'd0, mdone});
    chk("overflow", {63'd0, overflow}, {63'd0, movf});
    chk("skew_err", {63'd0, skew_err}, {63'd0, mskew});
    if (mv) begin
      chk("m_data", m_data, mdat);
      chk("m_last", {63'd0, m_last}, {63'd0, ml});
    end
  endtask
  task automatic aligned(input int i, input bit rdy);
    cyc(0, 1, 32'h1000 + 32'(i), 1, 32'h2000 + 32'(i), rdy);
  endtask
  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) cyc(0, 0, '0, 0, '0, rdy);
  endtask
  typedef struct {
    bit rst; bit v; int i; bit rdy;
    bit ev; logic [63:0] ed; bit el;
  } vec_t;
  vec_t tbl[7];
  int first_v;
  initial begin
    tbl[0] = '{1, 0, 0, 1, 0, 64'h0, 0};
    tbl[1] = '{0, 1, 0, 1, 0, 64'h0, 0};
    tbl[2] = '{0, 1, 1, 1, 1, 64'h00002000_00001000, 0};
    tbl[3] = '{0, 1, 2, 1, 1, 64'h00002001_00001001, 0};
    tbl[4] = '{0, 1, 3, 1, 1, 64'h00002002_00001002, 0};
    tbl[5] = '{0, 0, 0, 1, 1, 64'h00002003_00001003, 1};
    tbl[6] = '{0, 0, 0, 1, 0, 64'h0, 0};
    for (int t = 0; t < 7; t++) begin
      cyc(tbl[t].rst, tbl[t].v, 32'h1000 + 32'(tbl[t].i), tbl[t].v, 32'h2000 + 32'(tbl[t].i), tbl[t].rdy);
      chk("tbl_valid", {63'd0, m_valid}, {63'd0, tbl[t].ev});
      if (tbl[t].rst) chk("tbl_rst_data", m_data, 64'h0);
      if (tbl[t].ev) begin
        chk("tbl_data", m_data, tbl[t].ed);
        chk("tbl_last", {63'd0, m_last}, {63'd0, tbl[t].el});
      end
    end
    // aligned full frame
    cyc(1, 0, '0, 0, '0, 1);
    nacc = 0; nlast = 0;
    for (int i = 0; i < 12; i++) aligned(i, 1);
    idle(6, 1);
    chk("frame_words", 64'(nacc), 64'd12);
    chk("frame_lasts", 64'(nlast), 64'd3);
    chk("frame_done", {63'd0, done}, 64'd1);
    chk("frame_ovf", {63'd0, overflow}, 64'd0);
    // skewed lanes, lane1 leads by 5
    cyc(1, 0, '0, 0, '0, 1);
    first_v = -1;
    for (int t = 0; t < 13; t++) begin
      cyc(0, t < 8, 32'h1000 + 32'(t), t >= 5, 32'h2000 + 32'(t - 5), 1);
      if (first_v < 0 && m_valid) first_v = t;
    end
    idle(4, 1);
    chk("skew_first_valid", 64'(first_v), 64'd6);
    // backpressure
    cyc(1, 0, '0, 0, '0, 1);
    for (int i = 0; i < 4; i++) aligned(i, 1);
    for (int i = 4; i < 10; i++) aligned(i, 0);
    chk("bp_no_ovf", {63'd0, overflow}, 64'd0);
    idle(10, 1);
    // overflow
    cyc(1, 0, '0, 0, '0, 0);
    for (int i = 0; i < 10; i++) begin
      aligned(i, 0);
      if (i == 8) chk("ovf_before_drop", {63'd0, overflow}, 64'd0);
    end
    chk("ovf_after_drop", {63'd0, overflow}, 64'd1);
    nacc = 0;
    idle(15, 1);
    chk("ovf_drained", 64'(nacc), 64'd9);
    // full with same-cycle pop
    cyc(1, 0, '0, 0, '0, 0);
    for (int i = 0; i < 9; i++) aligned(i, 0);
    nacc = 0;
    aligned(9, 1);
    chk("full_pop_ovf", {63'd0, overflow}, 64'd0);
    idle(14, 1);
    chk("full_pop_words", 64'(nacc), 64'd10);
    // reset mid-burst
    cyc(1, 0, '0, 0, '0, 1);
    for (int i = 0; i < 4; i++) aligned(i, 1);
    cyc(1, 1, 32'h1111, 1, 32'h2222, 1);
    chk("rst_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_data", m_data, 64'd0);
    nacc = 0; nlast = 0;
    for (int i = 0; i < 8; i++) aligned(i, 1);
    idle(4, 1);
    chk("rst_restart_lasts", 64'(nlast), 64'd2);
    // random traffic
    cyc(1, 0, '0, 0, '0, 1);
    for (int t = 0; t < 3000; t++) begin
      bit r, a, b, rd;
      r  = ($urandom_range(0, 79) == 0);
      a  = ($urandom_range(0, 9) < 7);
      b  = ($urandom_range(0, 3) == 0) ? !a : a;
      rd = ($urandom_range(0, 3) != 0);
      cyc(r, a, $urandom, b, $urandom, rd);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
